// File: rtl/hex_digit_entry.sv
// hex_digit_entry: three edit buttons plus clear turned into an editable 16-bit
// hex value with a digit cursor and a blinking blank request for the display.
module hex_digit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned BLINK_BITS      = 22,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_clear,
    output logic [15:0] value,
    output logic [1:0]  cursor,
    output logic [3:0]  digit_blank,
    output logic        changed
);

    localparam int unsigned NBTN    = 4;
    localparam int unsigned CNT_W   = 20;
    localparam int unsigned B_NEXT  = 0;
    localparam int unsigned B_INC   = 1;
    localparam int unsigned B_DEC   = 2;
    localparam int unsigned B_CLEAR = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0]  raw_c;
    logic [NBTN-1:0]  pin_q;
    logic [NBTN-1:0]  s1_q;
    logic [NBTN-1:0]  s2_q;
    logic [NBTN-1:0]  stable_q;
    logic [NBTN-1:0]  stable_d;
    logic [NBTN-1:0]  stable_dly_q;
    logic [NBTN-1:0]  press_c;
    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];

    logic [15:0]           value_q, value_d;
    logic [1:0]            cursor_q, cursor_d;
    logic                  changed_q, changed_d;
    logic [3:0]            blank_q, blank_d;
    logic [BLINK_BITS-1:0] blink_cnt_q;
    logic [3:0]            nib_c;
    logic [3:0]            nib_idx_c;

    // Normalise polarity so 1 always means pressed.
    assign raw_c = {btn_clear, btn_dec, btn_inc, btn_next} ^ {NBTN{BTN_ACTIVE_LOW}};

    // Pin register followed by the two-flop synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
        end else begin
            pin_q <= raw_c;
            s1_q  <= pin_q;
            s2_q  <= s1_q;
        end
    end

    // Debounce: level must differ from stable for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < NBTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounced levels, their delayed copies and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int unsigned i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // One-cycle press events on debounced rising edges only.
    assign press_c   = stable_q & ~stable_dly_q;
    assign nib_idx_c = {cursor_q, 2'b00};
    assign nib_c     = value_q[nib_idx_c +: 4];

    // Edit logic: clear dominates, inc+dec cancel, next moves after the edit.
    always_comb begin
        value_d  = value_q;
        cursor_d = cursor_q;
        if (press_c[B_CLEAR]) begin
            value_d  = '0;
            cursor_d = '0;
        end else begin
            if (press_c[B_INC] && !press_c[B_DEC]) begin
                value_d[nib_idx_c +: 4] = nib_c + 4'd1;
            end else if (press_c[B_DEC] && !press_c[B_INC]) begin
                value_d[nib_idx_c +: 4] = nib_c - 4'd1;
            end
            if (press_c[B_NEXT]) begin
                cursor_d = cursor_q + 2'd1;
            end
        end
        changed_d = (value_d != value_q);
        blank_d   = blink_cnt_q[BLINK_BITS-1] ? 4'(4'b0001 << cursor_q) : 4'b0000;
    end

    // Value, cursor, change pulse, blink counter and blank request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q     <= '0;
            cursor_q    <= '0;
            changed_q   <= 1'b0;
            blank_q     <= '0;
            blink_cnt_q <= '0;
        end else begin
            value_q     <= value_d;
            cursor_q    <= cursor_d;
            changed_q   <= changed_d;
            blank_q     <= blank_d;
            blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
        end
    end

    assign value       = value_q;
    assign cursor      = cursor_q;
    assign changed     = changed_q;
    assign digit_blank = blank_q;

endmodule

// File: tb/tb_hex_digit_entry.sv
// Scoreboard bench for hex_digit_entry: stimulus pushes predicted updates,
// a negedge monitor pops and compares them, and checks the blink output.
module tb_hex_digit_entry;

    localparam int unsigned D  = 4;
    localparam int unsigned BB = 4;
    localparam logic [3:0] M_NEXT = 4'b0001;
    localparam logic [3:0] M_INC  = 4'b0010;
    localparam logic [3:0] M_DEC  = 4'b0100;
    localparam logic [3:0] M_CLR  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_next, btn_inc, btn_dec, btn_clear;
    logic [15:0] value;
    logic [1:0]  cursor;
    logic [3:0]  digit_blank;
    logic        changed;

    hex_digit_entry #(
        .DEBOUNCE_CYCLES(D),
        .BLINK_BITS     (BB),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_next   (btn_next),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .btn_clear  (btn_clear),
        .value      (value),
        .cursor     (cursor),
        .digit_blank(digit_blank),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        logic [1:0]  c;
        logic        ch;
        int          t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ecnt = 0;
    int   checks = 0;
    int   failures = 0;

    // Reference state: the value and cursor the user should have entered so far.
    logic [15:0] mv = '0;
    logic [1:0]  mc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] m);
        btn_next  = ~m[0];
        btn_inc   = ~m[1];
        btn_dec   = ~m[2];
        btn_clear = ~m[3];
    endtask

    // Apply one debounced event set to the model; queue the visible result.
    task automatic apply(input logic [3:0] m, input int t);
        logic [15:0] ov;
        logic [1:0]  oc;
        int          sh;
        int          nib;
        exp_t        e;
        ov = mv;
        oc = mc;
        if (m[3]) begin
            mv = '0;
            mc = '0;
        end else begin
            sh  = int'(mc) * 4;
            nib = int'((mv >> sh) & 16'hF);
            if (m[1] && !m[2])      nib = (nib + 1) % 16;
            else if (m[2] && !m[1]) nib = (nib + 15) % 16;
            mv = (mv & ~(16'hF << sh)) | (16'(nib) << sh);
            if (m[0]) mc = 2'((int'(mc) + 1) % 4);
        end
        if (mv != ov || mc != oc) begin
            e.v  = mv;
            e.c  = mc;
            e.ch = (mv != ov);
            e.t  = t;
            q.push_back(e);
        end
    endtask

    // Press at the cycle after the next edge; visible 3+D edges after the raw edge.
    task automatic press(input logic [3:0] m, input int hold, input int gap);
        @(posedge clk);
        #1;
        drive(m);
        apply(m, cyc + 4 + int'(D));
        repeat (hold) @(posedge clk);
        #1;
        drive(4'b0000);
        repeat (gap) @(posedge clk);
    endtask

    // Monitor: pop on every visible update, check change pulse and blink every cycle.
    logic [15:0] pv = '0;
    logic [1:0]  pc = '0;
    logic [1:0]  mon_c = '0;
    always @(negedge clk) begin
        exp_t        e;
        logic [3:0]  exp_blank;
        if (!rst_n) begin
            pv    = '0;
            pc    = '0;
            mon_c = '0;
        end else begin
            exp_blank = (ecnt > 0 && ((ecnt - 1) % (1 << BB)) >= (1 << (BB - 1)))
                        ? 4'(4'b0001 << mon_c) : 4'b0000;
            check("digit_blank", 32'(digit_blank), 32'(exp_blank));
            if (value !== pv || cursor !== pc) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update: value=%h cursor=%0d, required no change (cycle %0d)",
                             value, cursor, cyc);
                end else begin
                    e = q.pop_front();
                    check("update_cycle", 32'(cyc), 32'(e.t));
                    check("value", 32'(value), 32'(e.v));
                    check("cursor", 32'(cursor), 32'(e.c));
                    check("changed", 32'(changed), 32'(e.ch));
                    mon_c = e.c;
                end
            end else begin
                check("changed_idle", 32'(changed), 32'd0);
                if (q.size() > 0 && cyc > q[0].t) begin
                    e = q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL update_timeout: value=%h cursor=%0d, required value=%h cursor=%0d by cycle %0d",
                             value, cursor, e.v, e.c, e.t);
                    mon_c = e.c;
                end
            end
            pv = value;
            pc = cursor;
        end
    end

    initial begin
        logic [3:0] m;
        drive(4'b0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", 32'(value), 32'd0);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_changed", 32'(changed), 32'd0);
        check("rst_blank", 32'(digit_blank), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single press, long hold.
        press(M_INC, 20, 10);
        // 16 increments on digit 0 wrap without carry, then dec wraps 0 to F.
        for (int i = 0; i < 15; i++) press(M_INC, D, D + 2);
        press(M_DEC, D + 1, D + 3);
        press(M_CLR, D, D + 2);
        // Cursor walk to digit 3 and edit there.
        for (int i = 0; i < 3; i++) press(M_NEXT, D, D + 6);
        press(M_INC, D, D + 6);
        press(M_INC, D, 20);
        check("dir_value_2000", 32'(value), 32'h2000);
        check("dir_cursor_3", 32'(cursor), 32'd3);
        press(M_NEXT, D, 20);
        check("dir_cursor_wrap", 32'(cursor), 32'd0);

        // Same-cycle events.
        press(M_CLR, D, D + 2);
        press(M_NEXT, D, D + 2);
        press(M_NEXT | M_INC, D + 2, D + 4);
        press(M_INC | M_DEC, D + 2, D + 4);
        press(M_CLR | M_INC, D + 2, D + 4);
        press(M_INC, D, D + 2);

        // Bounce: toggle every 2 cycles, then hold steady.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            drive((i % 2 == 0) ? M_INC : 4'b0000);
            @(posedge clk);
        end
        press(M_INC, 10, 12);

        // Reset mid-debounce with inc held; held press must re-debounce fully.
        press(M_NEXT, D, D + 2);
        @(posedge clk);
        #1;
        drive(M_INC);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_value", 32'(value), 32'd0);
        check("midrst_cursor", 32'(cursor), 32'd0);
        check("midrst_changed", 32'(changed), 32'd0);
        check("midrst_blank", 32'(digit_blank), 32'd0);
        mv = '0;
        mc = '0;
        q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        apply(M_INC, cyc + 4 + int'(D));
        repeat (20) @(posedge clk);
        #1;
        drive(4'b0000);
        repeat (D + 4) @(posedge clk);

        // Randomised button combinations.
        for (int i = 0; i < 40; i++) begin
            m    = 4'($urandom_range(1, 7));
            m[3] = ($urandom_range(0, 7) == 0);
            press(m, int'($urandom_range(D, D + 8)), int'($urandom_range(D + 2, D + 10)));
        end

        repeat (30) @(posedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
